load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 207 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Memory-stage load/store unit in front of the word-addressed data
//             memory. Checks alignment and range, performs full-word accesses
//             only (sub-word stores use read-modify-write). Optional macro
//             LSU_SUBWORD_EN enables byte/halfword support.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int unsigned DEPTH     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_dir,
    output logic [31:0] mem_data_input,
    output logic        mem_rd,
    output logic        mem_wd,
    input  logic [31:0] mem_data_output
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // 33-bit bounds so the end address cannot wrap
    localparam logic [32:0] c_base  = {1'b0, BASE_ADDR};
    localparam logic [32:0] c_limit = c_base + 33'(4 * DEPTH);

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [32:0] w_addr_ext;
    logic        w_req_err;

`ifdef LSU_SUBWORD_EN
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  off_q, off_d;

    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic sgn);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   f_extract = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   f_extract = {{16{sgn & sh[15]}}, sh[15:0]};
            default: f_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [31:0] wdata,
                                            input logic [1:0] size, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                data = {24'h0, wdata[7:0]} << {off, 3'b000};
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {off[1], 4'b0000};
                data = {16'h0, wdata[15:0]} << {off[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        f_merge = (word & ~mask) | (data & mask);
    endfunction
`else
    logic w_unused;
    assign w_unused = req_signed;
`endif

    assign w_addr_ext = {1'b0, req_addr};

    always_comb begin
        w_req_err = 1'b0;
        if (req_size == 2'b11)                          w_req_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0])           w_req_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00) w_req_err = 1'b1;
        if (w_addr_ext < c_base || w_addr_ext >= c_limit) w_req_err = 1'b1;
`ifndef LSU_SUBWORD_EN
        if (!req_size[1])                               w_req_err = 1'b1;
`endif
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef LSU_SUBWORD_EN
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        off_d    = off_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr[31:2];
                    wdata_d  = req_wdata;
                    rdata_d  = 32'h0;
`ifdef LSU_SUBWORD_EN
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    off_d    = req_addr[1:0];
`endif
                    if (w_req_err) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (req_we && req_size == 2'b10) begin
                        err_d   = 1'b0;
                        state_d = S_WRITE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
`ifdef LSU_SUBWORD_EN
                if (we_q) begin
                    wdata_d = f_merge(mem_data_output, wdata_q, size_q, off_q);
                    state_d = S_WRITE;
                end else begin
                    rdata_d = f_extract(mem_data_output, size_q, off_q, signed_q);
                    state_d = S_RESP;
                end
`else
                rdata_d = mem_data_output;
                state_d = S_RESP;
`endif
            end
            S_WRITE: state_d = S_RESP;
            S_RESP: begin
                state_d = S_IDLE;
                rdata_d = 32'h0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef LSU_SUBWORD_EN
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            off_q    <= 2'b00;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef LSU_SUBWORD_EN
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            off_q    <= off_d;
`endif
        end
    end

    // Strobes are masked by reset so an aborted WRITE never commits
    assign req_ready      = (state_q == S_IDLE) && !reset;
    assign resp_valid     = (state_q == S_RESP) && !reset;
    assign resp_rdata     = rdata_q;
    assign resp_err       = err_q;
    assign mem_rd         = (state_q == S_READ) && !reset;
    assign mem_wd         = (state_q == S_WRITE) && !reset;
    assign mem_dir        = (state_q == S_IDLE) ? 32'h0 : {addr_q, 2'b00};
    assign mem_data_input = (state_q == S_WRITE) ? wdata_q : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Self-checking bench for load_store_unit: directed vector table,
//             reset/abort sequences and random requests against a byte-level
//             reference model. Honours LSU_SUBWORD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 64;
`ifdef LSU_SUBWORD_EN
    localparam bit SW = 1'b1;
`else
    localparam bit SW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_dir;
    logic [31:0] mem_data_input;
    logic        mem_rd;
    logic        mem_wd;
    logic [31:0] mem_data_output;
    logic        mem_clear = 1'b1;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    load_store_unit #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_dir(mem_dir), .mem_data_input(mem_data_input),
        .mem_rd(mem_rd), .mem_wd(mem_wd), .mem_data_output(mem_data_output)
    );

    // Word-addressed data memory: combinational read, write on posedge
    always_comb begin
        mem_data_output = 32'h0;
        if (mem_dir >= BASE && mem_dir < BASE + 4 * DEPTH)
            mem_data_output = mem[(mem_dir - BASE) >> 2];
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (mem_wd && mem_dir >= BASE && mem_dir < BASE + 4 * DEPTH) begin
            mem[(mem_dir - BASE) >> 2] <= mem_data_input;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-lane view of memory, updates ref_mem on stores
    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a_in, input logic [31:0] wd,
                         output logic e_err, output logic [31:0] e_rd,
                         output int e_lat, output logic [31:0] e_wdata);
        longint unsigned a, lo, hi, lanemask, valmask, val;
        int nbytes, off, w;
        a = a_in; lo = BASE; hi = BASE + 4 * DEPTH;
        e_err = 1'b0; e_rd = 32'h0; e_lat = 0; e_wdata = 32'h0;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (sz == 2'b11)                e_err = 1'b1;
        else if (a % nbytes != 0)       e_err = 1'b1;
        else if (a < lo || a >= hi)     e_err = 1'b1;
        else if (!SW && nbytes < 4)     e_err = 1'b1;
        if (e_err) begin
            e_lat = 1;
            return;
        end
        w = int'((a - lo) / 4);
        off = int'(a % 4);
        valmask = (64'd1 << (8 * nbytes)) - 1;
        lanemask = valmask << (8 * off);
        if (we) begin
            val = (64'(ref_mem[w]) & ~lanemask) | ((64'(wd) & valmask) << (8 * off));
            e_wdata = val[31:0];
            ref_mem[w] = e_wdata;
            e_lat = (nbytes == 4) ? 2 : 3;
        end else begin
            val = (64'(ref_mem[w]) >> (8 * off)) & valmask;
            if (sg && nbytes < 4 && val >= (64'd1 << (8 * nbytes - 1)))
                val = val + 64'h1_0000_0000 - (64'd1 << (8 * nbytes));
            e_rd = val[31:0];
            e_lat = 2;
        end
    endtask

    // Call at a negedge; returns at the negedge of the response cycle
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int nrd, output int nwd, output logic [31:0] dir_seen,
                          output logic [31:0] wdat_seen, output logic both);
        int cyc;
        rdata = 32'h0; err = 1'b0; lat = 0; nrd = 0; nwd = 0;
        dir_seen = 32'h0; wdat_seen = 32'h0; both = 1'b0;
        cyc = 0;
        while (!req_ready && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
            if (mem_rd) begin nrd++; dir_seen = mem_dir; end
            if (mem_wd) begin nwd++; dir_seen = mem_dir; wdat_seen = mem_data_input; end
            if (mem_rd && mem_wd) both = 1'b1;
        end while (!resp_valid && cyc < 10);
        lat = resp_valid ? cyc : 99;
        rdata = resp_rdata;
        err = resp_err;
    endtask

    task automatic run_check(input string tag, input logic we, input logic [1:0] sz,
                             input logic sg, input logic [31:0] a, input logic [31:0] wd,
                             input logic exp_err, input logic [31:0] exp_rd,
                             input int exp_lat, input logic [31:0] exp_mw);
        logic [31:0] rd, dir, wdat;
        logic        err, both;
        int          lat, nrd, nwd;
        do_req(we, sz, sg, a, wd, rd, err, lat, nrd, nwd, dir, wdat, both);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_nrd"}, 32'(nrd), (!exp_err && (!we || sz != 2'b10)) ? 32'd1 : 32'd0);
        check({tag, "_nwd"}, 32'(nwd), (!exp_err && we) ? 32'd1 : 32'd0);
        check({tag, "_both"}, {31'h0, both}, 32'h0);
        if (!exp_err) check({tag, "_dir"}, dir, a & ~32'h3);
        if (!exp_err && we) check({tag, "_mwdata"}, wdat, exp_mw);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] mw;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic        e_err, seen;
        logic [31:0] e_rd, e_mw, r_a, r_wd;
        logic [1:0]  r_sz;
        logic        r_we, r_sg;
        int          e_lat, cyc, r;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

        tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h0040_0008, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 32'hDEAD_BEEF};
        tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h0040_0008, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 32'h0};
        tbl[2]  = '{1'b1, 2'b00, 1'b0, 32'h0040_0009, 32'h0000_007F, !SW, 32'h0, SW ? 3 : 1, 32'hDEAD_7FEF};
        tbl[3]  = '{1'b0, 2'b10, 1'b0, 32'h0040_0008, 32'h0, 1'b0, SW ? 32'hDEAD_7FEF : 32'hDEAD_BEEF, 2, 32'h0};
        tbl[4]  = '{1'b0, 2'b00, 1'b1, 32'h0040_000B, 32'h0, !SW, SW ? 32'hFFFF_FFDE : 32'h0, SW ? 2 : 1, 32'h0};
        tbl[5]  = '{1'b0, 2'b00, 1'b0, 32'h0040_000B, 32'h0, !SW, SW ? 32'h0000_00DE : 32'h0, SW ? 2 : 1, 32'h0};
        tbl[6]  = '{1'b0, 2'b01, 1'b1, 32'h0040_000A, 32'h0, !SW, SW ? 32'hFFFF_DEAD : 32'h0, SW ? 2 : 1, 32'h0};
        tbl[7]  = '{1'b0, 2'b10, 1'b0, 32'h0040_0006, 32'h0, 1'b1, 32'h0, 1, 32'h0};
        tbl[8]  = '{1'b1, 2'b10, 1'b0, 32'h003F_FFFC, 32'h1234_5678, 1'b1, 32'h0, 1, 32'h0};
        tbl[9]  = '{1'b1, 2'b10, 1'b0, 32'h0040_0100, 32'h1234_5678, 1'b1, 32'h0, 1, 32'h0};
        tbl[10] = '{1'b0, 2'b10, 1'b0, 32'h0040_00FC, 32'h0, 1'b0, 32'h0, 2, 32'h0};
        tbl[11] = '{1'b0, 2'b11, 1'b0, 32'h0040_0000, 32'h0, 1'b1, 32'h0, 1, 32'h0};
        tbl[12] = '{1'b0, 2'b01, 1'b0, 32'h0040_0009, 32'h0, 1'b1, 32'h0, 1, 32'h0};
        tbl[13] = '{1'b0, 2'b00, 1'b0, 32'h0040_0000, 32'h0, !SW, 32'h0, SW ? 2 : 1, 32'h0};
        tbl[14] = '{1'b1, 2'b01, 1'b0, 32'h0040_000A, 32'h1234_CAFE, !SW, 32'h0, SW ? 3 : 1, 32'hCAFE_7FEF};
        tbl[15] = '{1'b0, 2'b01, 1'b0, 32'h0040_000A, 32'h0, !SW, SW ? 32'h0000_CAFE : 32'h0, SW ? 2 : 1, 32'h0};

        // Reset: strobes and ready held low, requests ignored
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = BASE;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("rst_mem_wd", {31'h0, mem_wd}, 32'h0);
        reset = 1'b0; req_valid = 1'b0; mem_clear = 1'b0;
        #1;
        check("rst_ready_after", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_mem_dir", mem_dir, 32'h0);
        check("rst_mem_data_input", mem_data_input, 32'h0);
        @(negedge clk);
        check("rst_ignored_req", {31'h0, mem_rd}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            model(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wdata, e_err, e_rd, e_lat, e_mw);
            run_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr,
                      tbl[i].wdata, tbl[i].err, tbl[i].rdata, tbl[i].lat, tbl[i].mw);
        end

        // Abort during WRITE: no commit, no response
        model(1'b1, 2'b10, 1'b0, 32'h0040_0010, 32'hA5A5_A5A5, e_err, e_rd, e_lat, e_mw);
        run_check("abort_setup", 1'b1, 2'b10, 1'b0, 32'h0040_0010, 32'hA5A5_A5A5, e_err, e_rd, e_lat, e_mw);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SW ? 2'b00 : 2'b10;
        req_addr = 32'h0040_0010; req_wdata = 32'h1122_3344;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
        end while (!mem_wd && cyc < 6);
        check("abort_reach_write", {31'h0, mem_wd}, 32'h1);
        reset = 1'b1;
        #1;
        check("abort_wd_forced", {31'h0, mem_wd}, 32'h0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("abort_no_resp", {31'h0, seen}, 32'h0);
        model(1'b0, 2'b10, 1'b0, 32'h0040_0010, 32'h0, e_err, e_rd, e_lat, e_mw);
        run_check("abort_readback", 1'b0, 2'b10, 1'b0, 32'h0040_0010, 32'h0, e_err, e_rd, e_lat, e_mw);

        // Random requests against the reference model
        for (int k = 0; k < 300; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)       r_a = BASE + $urandom_range(0, 31);
            else if (r < 7)  r_a = BASE + $urandom_range(0, 4 * DEPTH - 1);
            else if (r == 7) r_a = BASE - $urandom_range(1, 8);
            else if (r == 8) r_a = BASE + 4 * DEPTH + $urandom_range(0, 8);
            else             r_a = $urandom;
            r_sz = 2'($urandom_range(0, 3));
            if (r_sz != 2'b11 && $urandom_range(0, 3) != 0) begin
                if (r_sz == 2'b01) r_a[0] = 1'b0;
                if (r_sz == 2'b10) r_a[1:0] = 2'b00;
            end
            r_we = 1'($urandom_range(0, 1));
            r_sg = 1'($urandom_range(0, 1));
            r_wd = $urandom;
            model(r_we, r_sz, r_sg, r_a, r_wd, e_err, e_rd, e_lat, e_mw);
            run_check($sformatf("rnd%0d", k), r_we, r_sz, r_sg, r_a, r_wd, e_err, e_rd, e_lat, e_mw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
